probe_capture_readout: RTL and testbench

- Capture-and-readout back end for the probe set used on the UDP user-interface data buffer: probe0/1/2 (1 bit each) and probe3 (16 bits).
- Records probe samples into a circular buffer with pre-trigger history.
- After capture, reads the buffer oldest-first as a valid/ready word stream, so the UDP TX path can ship captures off-chip.

---
 rtl/probe_capture_pkg.sv | 26 ++
 rtl/probe_capture_ram.sv | 37 +++
 rtl/probe_capture_readout.sv | 186 ++++++++++++++++++
 tb/tb_probe_capture_readout.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_capture_pkg.sv
// Shared types, widths and word packing for the probe capture/readout block.
// Build option: PROBE_CAPTURE_TIMESTAMP_EN stores a 13-bit timestamp with every sample.
package probe_capture_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        READ = 3'd4
    } state_t;

    localparam int SAMPLE_W = 19;
    localparam int WORD_W   = 32;
    localparam int TS_W     = 13;

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    localparam int RAM_W = WORD_W;
`else
    localparam int RAM_W = SAMPLE_W;
`endif

    function automatic logic [WORD_W-1:0] pack_word(input logic [TS_W-1:0]     ts,
                                                     input logic [SAMPLE_W-1:0] s);
        return {ts, s};
    endfunction
endpackage

// File: rtl/probe_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The read register holds its value while re_i is low, so it doubles as a pipeline stage.
module probe_capture_ram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 19,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, held when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/probe_capture_readout.sv
// Probe capture with pre-trigger history and oldest-first valid/ready readout.
// Build option: PROBE_CAPTURE_TIMESTAMP_EN adds a 13-bit timestamp to each word.
module probe_capture_readout
    import probe_capture_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int PRE_TRIG = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        probe0,
    input  logic        probe1,
    input  logic        probe2,
    input  logic [15:0] probe3,
    input  logic        arm,
    input  logic        abort,
    input  logic [15:0] trig_mask,
    input  logic [15:0] trig_value,
    output logic        armed,
    output logic        triggered,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] PRE_TRIG_A = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] PRE_LAST   = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST  = ADDR_W'(DEPTH - PRE_TRIG - 2);
    localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_IDX   = (ADDR_W + 1)'(DEPTH - 1);

    state_t                state_q;
    logic [SAMPLE_W-1:0]   sample_q;
    logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q, trig_addr_q, cnt_q;
    logic [ADDR_W:0]       rd_cnt_q;
    logic                  stg_vld_q, stg_last_q;
    logic                  armed_q, triggered_q, m_valid_q, m_last_q;
    logic [WORD_W-1:0]     m_data_q;

    logic                  match_s, wr_en_s, advance_s, issue_s, last_xfer_s;
    logic [RAM_W-1:0]      wr_data_s, ram_rdata_s;
    logic [WORD_W-1:0]     word_s;

    assign match_s     = ((sample_q[18:3] & trig_mask) == (trig_value & trig_mask));
    assign wr_en_s     = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
    // Output register and RAM stage advance together, so a stall freezes both.
    assign advance_s   = !m_valid_q || m_ready;
    assign issue_s     = (state_q == READ) && advance_s && (rd_cnt_q != DEPTH_C);
    assign last_xfer_s = m_valid_q && m_ready && m_last_q;

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    // The arm cycle counts as 0, so the first stored sample carries 1.
    always_comb begin
        if ((state_q == IDLE) && arm) begin
            ts_d = 13'd1;
        end else begin
            ts_d = ts_q + 13'd1;
        end
    end

    // Free-running timestamp register.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            ts_q <= 13'd0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_data_s = pack_word(ts_q, sample_q);
    assign word_s    = ram_rdata_s;
`else
    assign wr_data_s = sample_q;
    assign word_s    = pack_word(13'd0, ram_rdata_s);
`endif

    // Control FSM, pointers, readout pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_addr_q <= '0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            stg_vld_q   <= 1'b0;
            stg_last_q  <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
        end else begin
            sample_q <= {probe3, probe2, probe1, probe0};
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q <= PRE;
                        cnt_q   <= '0;
                        armed_q <= 1'b1;
                    end
                end
                PRE: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (match_s) begin
                        trig_addr_q <= wr_ptr_q;
                        cnt_q       <= '0;
                        state_q     <= POST;
                        armed_q     <= 1'b0;
                        triggered_q <= 1'b1;
                    end
                end
                POST: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (cnt_q == POST_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= READ;
                        rd_ptr_q <= trig_addr_q - PRE_TRIG_A;
                        rd_cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                READ: begin
                    if (issue_s) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                    if (advance_s) begin
                        stg_vld_q  <= issue_s;
                        stg_last_q <= issue_s && (rd_cnt_q == LAST_IDX);
                        m_valid_q  <= stg_vld_q;
                        m_last_q   <= stg_last_q;
                        m_data_q   <= word_s;
                    end
                    if (last_xfer_s) begin
                        state_q     <= IDLE;
                        triggered_q <= 1'b0;
                        stg_vld_q   <= 1'b0;
                        stg_last_q  <= 1'b0;
                        m_valid_q   <= 1'b0;
                        m_last_q    <= 1'b0;
                        m_data_q    <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    probe_capture_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (RAM_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_s),
        .re_i    (issue_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata_s)
    );

    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
endmodule

// File: tb/tb_probe_capture_readout.sv
// Directed bench for probe_capture_readout at DEPTH=16, PRE_TRIG=4.
// Probes follow a cycle counter so every expected word is computed from the arm cycle.
module tb_probe_capture_readout;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        probe0 = 1'b0, probe1 = 1'b0, probe2 = 1'b0;
    logic [15:0] probe3 = 16'h0000;
    logic        arm = 1'b0, abort = 1'b0, m_ready = 1'b0;
    logic [15:0] trig_mask = 16'hFFFF, trig_value = 16'h0000;
    logic        armed, triggered, m_valid, m_last;
    logic [31:0] m_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mode     = 0;

    logic [31:0] got_q[$];
    bit          got_last_q[$];
    int          stall_err;
    bit          tmo;

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    localparam logic [31:0] CMP_MASK = 32'h0007FFFF;
`else
    localparam logic [31:0] CMP_MASK = 32'hFFFFFFFF;
`endif

    always #5 clk = ~clk;

    probe_capture_readout #(.DEPTH(16), .PRE_TRIG(4)) dut (
        .clk(clk), .rst(rst), .probe0(probe0), .probe1(probe1), .probe2(probe2),
        .probe3(probe3), .arm(arm), .abort(abort), .trig_mask(trig_mask),
        .trig_value(trig_value), .armed(armed), .triggered(triggered),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    function automatic logic [31:0] exp_word(input int c, input int md);
        logic [15:0] p3;
        logic [2:0]  lo;
        if (md == 0) p3 = c[15:0];
        else         p3 = 16'h0100 | 16'(c % 10);
        lo = c[2:0];
        return {13'd0, p3, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        probe0 = cyc[0];
        probe1 = cyc[1];
        probe2 = cyc[2];
        if (mode == 0) probe3 = cyc[15:0];
        else           probe3 = 16'h0100 | 16'(cyc % 10);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic collect(input int n, input int budget, input bit bp);
        logic [15:0] pat;
        bit          prev_stall, done;
        logic [31:0] pd;
        logic        pl, pv;
        pat = 16'b1011_0010_1110_0101;
        got_q.delete();
        got_last_q.delete();
        stall_err = 0;
        prev_stall = 1'b0;
        done = 1'b0;
        pd = 32'd0; pl = 1'b0; pv = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (prev_stall && (m_valid !== pv || m_data !== pd || m_last !== pl))
                stall_err++;
            m_ready = bp ? pat[k % 16] : 1'b1;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last_q.push_back(m_last);
                if (m_last || got_q.size() == n) done = 1'b1;
            end
            prev_stall = m_valid && !m_ready;
            pv = m_valid; pd = m_data; pl = m_last;
            tick();
            if (done) break;
        end
        tmo = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({armed, triggered, m_valid, m_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {armed, triggered, m_valid, m_last});
        end
        n_checks++;
        if (m_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00000000", m_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        mode = 0; trig_mask = 16'hFFFF; trig_value = 16'h0020;
        while (cyc < 16) tick();
        do_arm();
        n_checks++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_armed: got %b expected 1", armed);
        end
        collect(16, 200, 1'b0);
        n_checks++;
        if (tmo || got_q.size() != 16) begin
            n_fail++;
            $display("FAIL basic_count: got %0d words expected 16", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (((got_q[i] & CMP_MASK) !== exp_word(16'h001C + i, 0)) || (got_last_q[i] !== (i == 15))) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %h last %b expected %h last %b", i, got_q[i],
                         got_last_q[i], exp_word(16'h001C + i, 0), (i == 15));
            end
        end
        n_checks++;
        if ({armed, triggered, m_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_idle: got %b expected 000", {armed, triggered, m_valid});
        end
    endtask

    task automatic test_pre_ignore();
        int c0;
        mode = 1; trig_mask = 16'hFFFF; trig_value = 16'h0101;
        tick();
        while (cyc % 10 != 0) tick();
        c0 = cyc;
        do_arm();
        collect(16, 200, 1'b0);
        n_checks++;
        if (tmo || got_q.size() != 16) begin
            n_fail++;
            $display("FAIL pre_count: got %0d words expected 16", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (((got_q[i] & CMP_MASK) !== exp_word(c0 + 7 + i, 1)) || (got_last_q[i] !== (i == 15))) begin
                n_fail++;
                $display("FAIL pre_word%0d: got %h expected %h", i, got_q[i], exp_word(c0 + 7 + i, 1));
            end
        end
        n_checks++;
        if (got_q.size() < 5 || got_q[4][18:3] !== 16'h0101) begin
            n_fail++;
            $display("FAIL pre_trig_pos: 5th word probe3 not 0101 (words=%0d)", got_q.size());
        end
    endtask

    task automatic test_backpressure();
        int c0;
        mode = 0; trig_mask = 16'hFFFF;
        tick();
        c0 = cyc;
        trig_value = 16'(c0 + 8);
        do_arm();
        collect(16, 300, 1'b1);
        n_checks++;
        if (tmo || got_q.size() != 16) begin
            n_fail++;
            $display("FAIL bp_count: got %0d transfers expected 16", got_q.size());
        end
        n_checks++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d stall violations expected 0", stall_err);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (((got_q[i] & CMP_MASK) !== exp_word(c0 + 4 + i, 0)) || (got_last_q[i] !== (i == 15))) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h expected %h", i, got_q[i], exp_word(c0 + 4 + i, 0));
            end
        end
    endtask

    task automatic test_mask_zero();
        int c0;
        mode = 0; trig_mask = 16'h0000; trig_value = 16'hBEEF;
        tick();
        c0 = cyc;
        do_arm();
        tick(); tick(); tick(); tick();
        n_checks++;
        if (triggered !== 1'b0) begin
            n_fail++;
            $display("FAIL mz_trig5: got %b expected 0", triggered);
        end
        tick();
        n_checks++;
        if (triggered !== 1'b1) begin
            n_fail++;
            $display("FAIL mz_trig6: got %b expected 1", triggered);
        end
        collect(16, 200, 1'b0);
        n_checks++;
        if (tmo || got_q.size() != 16) begin
            n_fail++;
            $display("FAIL mz_count: got %0d words expected 16", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (((got_q[i] & CMP_MASK) !== exp_word(c0 + i, 0)) || (got_last_q[i] !== (i == 15))) begin
                n_fail++;
                $display("FAIL mz_word%0d: got %h expected %h", i, got_q[i], exp_word(c0 + i, 0));
            end
        end
    endtask

    task automatic test_abort_rearm();
        int c0, c1;
        mode = 0; trig_mask = 16'hFFFF;
        tick();
        c0 = cyc;
        trig_value = 16'(c0 + 6);
        do_arm();
        for (int k = 0; k < 64 && !triggered; k++) tick();
        n_checks++;
        if (triggered !== 1'b1) begin
            n_fail++;
            $display("FAIL ab_trig: got %b expected 1", triggered);
        end
        do_arm();
        n_checks++;
        if (armed !== 1'b0) begin
            n_fail++;
            $display("FAIL ab_post_arm: armed got %b expected 0", armed);
        end
        collect(7, 200, 1'b0);
        n_checks++;
        if (tmo || got_q.size() != 7) begin
            n_fail++;
            $display("FAIL ab_part_count: got %0d words expected 7", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (((got_q[i] & CMP_MASK) !== exp_word(c0 + 2 + i, 0)) || (got_last_q[i] !== 1'b0)) begin
                n_fail++;
                $display("FAIL ab_part%0d: got %h expected %h", i, got_q[i], exp_word(c0 + 2 + i, 0));
            end
        end
        m_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({m_valid, m_last, triggered} !== 3'b000) begin
            n_fail++;
            $display("FAIL ab_drop: got %b expected 000", {m_valid, m_last, triggered});
        end
        m_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ab_quiet: m_valid got %b expected 0", m_valid);
        end
        c1 = cyc;
        trig_value = 16'(c1 + 5);
        do_arm();
        collect(16, 200, 1'b0);
        n_checks++;
        if (tmo || got_q.size() != 16) begin
            n_fail++;
            $display("FAIL ab_rearm_count: got %0d words expected 16", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (((got_q[i] & CMP_MASK) !== exp_word(c1 + 1 + i, 0)) || (got_last_q[i] !== (i == 15))) begin
                n_fail++;
                $display("FAIL ab_rearm%0d: got %h expected %h", i, got_q[i], exp_word(c1 + 1 + i, 0));
            end
        end
    endtask

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [12:0] d;
        mode = 0; trig_mask = 16'h0000;
        tick();
        do_arm();
        collect(16, 200, 1'b0);
        n_checks++;
        if (got_q.size() != 16 || got_q[0][31:19] !== 13'd1) begin
            n_fail++;
            $display("FAIL ts_first: got %h expected timestamp 1 (words=%0d)",
                     (got_q.size() > 0) ? got_q[0] : 32'd0, got_q.size());
        end
        for (int i = 1; i < got_q.size(); i++) begin
            d = got_q[i][31:19] - got_q[i-1][31:19];
            n_checks++;
            if (d !== 13'd1) begin
                n_fail++;
                $display("FAIL ts_step%0d: got delta %0d expected 1", i, d);
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_pre_ignore();
        test_backpressure();
        test_mask_zero();
        test_abort_rearm();
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
